// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding and default bus
// widths used by both the master bridge and the APB memory slave.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for the APB master bridge. Cleared before each
// ACCESS phase, counts stalled cycles and flags the last permitted one.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count stalled ACCESS cycles; saturate once the limit is reached.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // High during the LIMIT-th stalled cycle, so the abort edge ends exactly
  // LIMIT ACCESS cycles after entry.
  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: accepts one host command at a time, runs it through the
// SETUP and ACCESS phases and returns a one-cycle response strobe.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// that waits TIMEOUT_CYC cycles without pready (reported as an error).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state;
  logic       timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .pclk   (pclk),
    .reset  (reset),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !pready),
    .expired(timeout)
  );
`else
  // Without the timeout the bridge waits on pready indefinitely; the limit
  // parameter is kept for a uniform interface but has no effect here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  // Only one transfer in flight: commands are taken only while idle.
  assign cmd_ready = (state == IDLE);

  // Transfer sequencing with registered APB and response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge reset) begin
    // NOTE: asynchronous reset clears every output register at once, which
    // also aborts an in-flight transfer without a response strobe.
    if (!reset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            // Reads leave the last write data on the bus.
            if (cmd_write) pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout hitting in the same cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
            state     <= IDLE;
          end else if (timeout) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
